// File: rtl/spi_master_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_fifo
// Brief    : Register-mapped SPI master with TX/RX FIFOs, programmable
//            CPOL/CPHA, clock divider and one-hot slave selects.
//            Optional macro SPI_LSB_FIRST_EN enables MODE bit3 (lsb_first).
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_fifo #(
   parameter int         NUM_SS     = 4,
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] DIV_RESET  = 8'h30
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [7:0]        addr,
   input  logic [7:0]        cpu_di,
   output logic [7:0]        cpu_do,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [NUM_SS-1:0] spi_ss,
   output logic              irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_ss_en, r_ovf;
   logic [7:0]        r_div, r_mode;
   logic [7:0]        r_tx_mem [FIFO_DEPTH];
   logic [7:0]        r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [CW-1:0]     r_tx_cnt, r_rx_cnt;
   logic              r_cpha_l, r_lsb_l;
   logic [7:0]        r_div_l, r_cnt, r_tx_sh, r_rx_sh;
   logic [4:0]        r_tog;
   logic              r_sck, r_mosi, r_irq;
   logic [7:0]        r_do;
   logic [NUM_SS-1:0] r_ss;

   logic w_sel_data, w_sel_ctrl, w_sel_div, w_sel_mode;
   logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_ovf;
   logic w_lsb_first, w_di_lsb, w_idle, w_next_bit, w_sample;
   logic [7:0] w_status, w_tx_head, w_rx_head, w_tx_sh_nx, w_rx_sh_nx;
   logic [4:0] w_tog_n;
   logic       w_unused_addr;

   // Only addr[1:0] selects a register; upper address bits are ignored.
   assign w_unused_addr = ^addr[7:2];

   assign w_sel_data = (addr[1:0] == 2'd0);
   assign w_sel_ctrl = (addr[1:0] == 2'd1);
   assign w_sel_div  = (addr[1:0] == 2'd2);
   assign w_sel_mode = (addr[1:0] == 2'd3);

`ifdef SPI_LSB_FIRST_EN
   assign w_lsb_first = r_mode[3];
   assign w_di_lsb    = cpu_di[3];
`else
   assign w_lsb_first = 1'b0;
   assign w_di_lsb    = 1'b0;
`endif

   assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_tx_push  = wr && w_sel_data && !w_tx_full;
   assign w_tx_pop   = (r_state == S_LOAD);
   assign w_rx_push  = (r_state == S_DONE) && !w_rx_full;
   assign w_rx_pop   = rd && w_sel_data && !w_rx_empty;
   assign w_rx_ovf   = (r_state == S_DONE) && w_rx_full;
   assign w_tx_head  = r_tx_mem[r_tx_rp];
   assign w_rx_head  = r_rx_mem[r_rx_rp];
   assign w_idle     = w_tx_empty && (r_state == S_IDLE);
   assign w_status   = {3'b000, r_ovf, w_idle, w_tx_full, !w_rx_empty, r_ss_en};

   // Shift helpers follow the bit order latched for the current byte.
   assign w_tog_n    = r_tog + 5'd1;
   assign w_sample   = (w_tog_n[0] != r_cpha_l);
   assign w_next_bit = r_lsb_l ? r_tx_sh[0] : r_tx_sh[7];
   assign w_tx_sh_nx = r_lsb_l ? {1'b0, r_tx_sh[7:1]} : {r_tx_sh[6:0], 1'b0};
   assign w_rx_sh_nx = r_lsb_l ? {spi_miso, r_rx_sh[7:1]} : {r_rx_sh[6:0], spi_miso};

   // Control registers; an overflow event wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ss_en <= 1'b0;
         r_ovf   <= 1'b0;
         r_div   <= DIV_RESET;
         r_mode  <= 8'h00;
      end else begin
         if (wr && w_sel_ctrl) r_ss_en <= cpu_di[0];
         if (wr && w_sel_div)  r_div   <= cpu_di;
         if (wr && w_sel_mode) r_mode  <= {cpu_di[7:4], w_di_lsb, cpu_di[2:0]};
         if (w_rx_ovf)                            r_ovf <= 1'b1;
         else if (wr && w_sel_ctrl && cpu_di[4])  r_ovf <= 1'b0;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= cpu_di;
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
   end

   // FIFO pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
         r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
         r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      end
   end

   // Shift engine: one byte is LOAD + 16 half-periods + DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_sck    <= 1'b0;
         r_mosi   <= 1'b0;
         r_cpha_l <= 1'b0;
         r_lsb_l  <= 1'b0;
         r_div_l  <= 8'h00;
         r_cnt    <= 8'h00;
         r_tx_sh  <= 8'h00;
         r_rx_sh  <= 8'h00;
         r_tog    <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_sck <= r_mode[0];
               if (!w_tx_empty) r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_sck    <= r_mode[0];
               r_cpha_l <= r_mode[1];
               r_lsb_l  <= w_lsb_first;
               r_div_l  <= r_div;
               r_cnt    <= r_div;
               r_tog    <= 5'd0;
               r_rx_sh  <= 8'h00;
               if (!r_mode[1]) begin
                  // Leading-edge sampling needs the first bit on the line now.
                  r_mosi  <= w_lsb_first ? w_tx_head[0] : w_tx_head[7];
                  r_tx_sh <= w_lsb_first ? {1'b0, w_tx_head[7:1]} : {w_tx_head[6:0], 1'b0};
               end else begin
                  r_tx_sh <= w_tx_head;
               end
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_cnt == 8'h00) begin
                  r_cnt <= r_div_l;
                  r_sck <= ~r_sck;
                  r_tog <= w_tog_n;
                  if (w_sample) begin
                     r_rx_sh <= w_rx_sh_nx;
                  end else if (w_tog_n != 5'd16) begin
                     r_mosi  <= w_next_bit;
                     r_tx_sh <= w_tx_sh_nx;
                  end
                  if (w_tog_n == 5'd16) r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 8'h01;
               end
            end
            default: begin
               r_state <= w_tx_empty ? S_IDLE : S_LOAD;
            end
         endcase
      end
   end

   // Registered bus read data, slave selects and interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_do  <= 8'h00;
         r_ss  <= '0;
         r_irq <= 1'b0;
      end else begin
         r_do <= 8'h00;
         if (rd) begin
            case (addr[1:0])
               2'd0:    r_do <= w_rx_empty ? 8'h00 : w_rx_head;
               2'd1:    r_do <= w_status;
               2'd2:    r_do <= r_div;
               default: r_do <= r_mode;
            endcase
         end
         for (int i = 0; i < NUM_SS; i++)
            r_ss[i] <= r_ss_en && (r_mode[7:4] == 4'(i));
         r_irq <= r_mode[2] && (!w_rx_empty || r_ovf);
      end
   end

   assign cpu_do   = r_do;
   assign spi_sck  = r_sck;
   assign spi_mosi = r_mosi;
   assign spi_ss   = r_ss;
   assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_fifo
// Brief    : Self-checking bench for spi_master_fifo, MOSI looped to MISO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_fifo;
   localparam int         NUM_SS     = 4;
   localparam int         FIFO_DEPTH = 8;
   localparam logic [7:0] DIV_RESET  = 8'h30;
`ifdef SPI_LSB_FIRST_EN
   localparam logic [7:0] MODE_FF    = 8'hFF;
`else
   localparam logic [7:0] MODE_FF    = 8'hF7;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              wr = 1'b0, rd = 1'b0;
   logic [7:0]        addr = 8'h00, cpu_di = 8'h00;
   logic [7:0]        cpu_do;
   logic              spi_sck, spi_mosi, spi_miso, irq;
   logic [NUM_SS-1:0] spi_ss;

   assign spi_miso = spi_mosi;

   always #5 clk = ~clk;

   spi_master_fifo #(
      .NUM_SS(NUM_SS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(DIV_RESET)
   ) u_dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr),
      .cpu_di(cpu_di), .cpu_do(cpu_do), .spi_sck(spi_sck),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss), .irq(irq)
   );

   typedef struct {
      logic [1:0] a;
      logic [7:0] wd;
      logic [7:0] exp;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic       prev_sck = 1'b0;
   int         tog_t[$];
   logic       mosi_q[$];
   logic [7:0] sb[$];

   // Edge monitor: timestamps every SCK toggle, captures MOSI on rising SCK.
   always @(negedge clk) begin
      cyc++;
      if (spi_sck !== prev_sck) begin
         tog_t.push_back(cyc);
         if (spi_sck) mosi_q.push_back(spi_mosi);
      end
      prev_sck = spi_sck;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus tasks are entered and left on a falling clock edge.
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      addr = {6'b0, a}; cpu_di = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      addr = {6'b0, a}; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = cpu_do;
   endtask

   task automatic send(input logic [7:0] d);
      bus_write(2'd0, d);
      sb.push_back(d);
   endtask

   task automatic read_rx(input string name);
      logic [7:0] d, e;
      bus_read(2'd0, d);
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s: scoreboard empty, got 0x%0h", name, d);
      end else begin
         e = sb.pop_front();
         check(name, d, e);
      end
   endtask

   task automatic wait_idle(input string name);
      logic [7:0] s;
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         bus_read(2'd1, s);
         if (s[3]) done = 1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL %s: engine never idle, got 0 expected 1", name);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      tog_t.delete();
      mosi_q.delete();
      @(negedge clk);
   endtask

   initial begin
      vec_t        vt[8];
      logic [7:0]  d;
      logic [15:0] m;

      vt[0] = '{2'd2, 8'h5A, 8'h5A};
      vt[1] = '{2'd2, 8'hFF, 8'hFF};
      vt[2] = '{2'd3, 8'h04, 8'h04};
      vt[3] = '{2'd3, 8'hFF, MODE_FF};
      vt[4] = '{2'd3, 8'h00, 8'h00};
      vt[5] = '{2'd1, 8'h01, 8'h09};
      vt[6] = '{2'd1, 8'h11, 8'h09};
      vt[7] = '{2'd1, 8'h00, 8'h08};

      // Reset values
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ss", spi_ss, 0);
      check("rst_sck", spi_sck, 0);
      check("rst_mosi", spi_mosi, 0);
      check("rst_irq", irq, 0);
      check("rst_cpu_do", cpu_do, 0);
      reset = 1'b0;
      @(negedge clk);
      bus_read(2'd1, d); check("rst_stat", d, 8'h08);
      bus_read(2'd2, d); check("rst_div", d, DIV_RESET);
      @(negedge clk);
      check("cpu_do_no_rd", cpu_do, 0);
      bus_read(2'd3, d); check("rst_mode", d, 8'h00);
      bus_read(2'd0, d); check("rst_data", d, 8'h00);

      // Register write/read vectors
      for (int i = 0; i < 8; i++) begin
         bus_write(vt[i].a, vt[i].wd);
         bus_read(vt[i].a, d);
         check($sformatf("reg_vec%0d", i), d, vt[i].exp);
      end

      // Mode 0, DIV=0 loopback, two bytes back to back
      bus_write(2'd2, 8'h00);
      bus_write(2'd3, 8'h00);
      clear_mon();
      send(8'hA5);
      send(8'h5A);
      wait_idle("m0_idle");
      check("m0_toggles", tog_t.size(), 32);
      if (tog_t.size() >= 17) begin
         check("m0_in_byte_span", tog_t[15] - tog_t[0], 15);
         check("m0_byte_period", tog_t[16] - tog_t[0], 18);
      end
      check("m0_mosi_count", mosi_q.size(), 16);
      m = 16'h0000;
      for (int i = 0; i < mosi_q.size() && i < 16; i++) m = {m[14:0], mosi_q[i]};
      check("m0_mosi_wave", m, 16'hA55A);
      check("m0_sck_end", spi_sck, 0);
      read_rx("m0_rx0");
      read_rx("m0_rx1");

      // Burst of FIFO_DEPTH+2 writes with DIV=3, no reads -> overflow
      bus_write(2'd2, 8'h03);
      bus_write(2'd3, 8'h04);
      clear_mon();
      for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
         bus_write(2'd0, 8'h10 + 8'(i));
         if (i <= FIFO_DEPTH) sb.push_back(8'h10 + 8'(i));
      end
      bus_read(2'd1, d); check("burst_tx_full", d, 8'h04);
      wait_idle("burst_idle");
      check("burst_toggles", tog_t.size(), 16 * (FIFO_DEPTH + 1));
      if (tog_t.size() >= 17) begin
         check("burst_period", tog_t[16] - tog_t[0], 66);
         check("burst_gap", tog_t[16] - tog_t[15], 6);
      end
      bus_read(2'd1, d); check("ovf_stat", d, 8'h1A);
      check("ovf_irq", irq, 1);
      for (int i = 0; i < FIFO_DEPTH; i++) read_rx($sformatf("burst_rx%0d", i));
      sb.delete();
      bus_read(2'd0, d); check("drained_read", d, 8'h00);
      check("irq_ovf_held", irq, 1);
      bus_write(2'd1, 8'h10);
      repeat (2) @(negedge clk);
      check("irq_cleared", irq, 0);
      bus_read(2'd1, d); check("ovf_cleared", d, 8'h08);

      // CPOL=1, CPHA=1, device 2
      bus_write(2'd2, 8'h00);
      bus_write(2'd3, 8'h23);
      bus_write(2'd1, 8'h01);
      repeat (2) @(negedge clk);
      check("m3_ss", spi_ss, 4'b0100);
      check("m3_sck_idle", spi_sck, 1);
      clear_mon();
      send(8'h3C);
      wait_idle("m3_idle");
      check("m3_toggles", tog_t.size(), 16);
      m = 16'h0000;
      for (int i = 0; i < mosi_q.size() && i < 8; i++) m = {m[14:0], mosi_q[i]};
      check("m3_mosi_wave", m, 16'h003C);
      check("m3_sck_end", spi_sck, 1);
      read_rx("m3_rx");
      bus_write(2'd3, 8'h53);
      repeat (2) @(negedge clk);
      check("ss_out_of_range", spi_ss, 4'b0000);

      // Empty read must not disturb the RX pointers
      bus_read(2'd0, d); check("empty_read", d, 8'h00);
      bus_read(2'd1, d); check("empty_stat", d, 8'h09);
      bus_write(2'd3, 8'h00);
      send(8'h69);
      wait_idle("empty_idle");
      read_rx("after_empty_rx");

      // Reset in the middle of a byte
      bus_write(2'd2, 8'h03);
      bus_write(2'd3, 8'h21);
      bus_write(2'd0, 8'hC3);
      bus_write(2'd0, 8'h77);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_sck", spi_sck, 0);
      check("mid_rst_ss", spi_ss, 0);
      check("mid_rst_mosi", spi_mosi, 0);
      check("mid_rst_irq", irq, 0);
      reset = 1'b0;
      @(negedge clk);
      bus_read(2'd1, d); check("mid_rst_stat", d, 8'h08);
      bus_read(2'd0, d); check("mid_rst_data", d, 8'h00);
      bus_read(2'd2, d); check("mid_rst_div", d, DIV_RESET);
      bus_read(2'd3, d); check("mid_rst_mode", d, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
CPU-register-mapped SPI master with an integrated shift engine, TX/RX FIFOs, parametrised slave-select count and programmable CPOL/CPHA. It replaces the single-byte controller-plus-external-shifter pair. It sits on the 8-bit peripheral bus, which uses wr/rd strobes, an 8-bit addr, and registered read data.

Parameters:
NUM_SS, 4, number of slave-select outputs (1..16)
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, >=2
DIV_RESET, 8'h30, reset value of the clock divider register

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
wr  in  1  bus write strobe, one cycle
rd  in  1  bus read strobe, one cycle
addr  in  8  register address; only [1:0] decoded
cpu_di  in  8  write data
cpu_do  out  8  registered read data; 0 when no read
spi_sck  out  1  SPI clock
spi_mosi  out  1  SPI data out
spi_miso  in  1  SPI data in
spi_ss  out  NUM_SS  slave selects, active-high, registered, one-hot or zero
irq  out  1  level interrupt

Behaviour:
- Clocking: clk drives all logic; reset is synchronous, active-high.
- Register map, addr[1:0]:
  - 0 DATA: write pushes TX. Read pops RX and returns the head; an empty read returns 0 with no pointer change.
  - 1 CTRL/STAT:
    - Write: bit0 ss_en; writing 1 to bit4 clears ovf.
    - Read: bit0 ss_en, bit1 rx_not_empty, bit2 tx_full, bit3 idle (TX empty and engine in IDLE), bit4 ovf, bits[7:5] 0.
  - 2 DIV: R/W. SCK half-period = DIV+1 clk cycles.
  - 3 MODE: R/W. bit0 cpol, bit1 cpha, bit2 irq_en, bit3 see optional feature, bits[7:4] dev_num.
- cpu_do: updates one clk after rd; it is 0 on every cycle without rd.
- Reset values: cpu_do=0, FIFOs empty, ss_en=0, ovf=0, DIV=DIV_RESET, MODE=0, spi_sck=0, spi_mosi=0, spi_ss=0, irq=0, engine in IDLE.
- spi_ss:
  - Registered each clk: bit dev_num=1 iff ss_en and dev_num<NUM_SS.
  - Out-of-range dev_num: all bits 0.
  - The engine does not gate SS; software owns framing.
- FIFO rules:
  - Write when TX is full: data dropped, no error flag.
  - A TX push and an engine pop in the same cycle are both honoured; likewise for RX.
  - Occupancy counter is width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Engine FSM IDLE -> LOAD -> SHIFT -> DONE -> (LOAD if TX not empty, else IDLE):
  - IDLE: spi_sck=cpol. Leave when TX not empty.
  - LOAD (1 clk): pop TX into the shift register, latch cpol/cpha/DIV for the whole byte. If cpha=0, drive first bit on mosi.
  - SHIFT:
    - Half-period counter counts DIV..0; spi_sck toggles at each terminal count.
    - Exactly 16 toggles per byte; spi_sck ends at cpol.
    - cpha=0: sample miso on odd toggles, shift mosi on even toggles 2..14.
    - cpha=1: shift mosi on odd toggles, sample miso on even toggles.
  - DONE (1 clk): push the received byte to RX. If RX is full, drop the byte and set ovf (sticky).
  - Byte period: 16*(DIV+1)+2 clk. MODE/DIV writes during SHIFT take effect at the next LOAD.
- Bit order: MSB first.
- irq: registered, equal to irq_en & (rx_not_empty | ovf).
- Reset mid-byte: transfer aborted, FIFO contents discarded, all outputs return to reset values on the next clk.

Optional Feature:
SPI_LSB_FIRST_EN:
- Defined: MODE bit3 is lsb_first, R/W, reset 0, latched at LOAD. When 1, TX shifts out LSB first and RX assembles LSB first.
- Undefined: bit3 reads 0, writes are ignored, MSB first always.

Test Plan:
- Reset, then read regs 1/2/3 -> 0x08, DIV_RESET, 0x00; spi_ss=0, spi_sck=0, irq=0.
- Loopback with DIV=0, mode 0: write DATA=0xA5 -> 16 sck toggles, byte takes 18 clk; DATA read returns 0xA5; mosi waveform 1,0,1,0,0,1,0,1.
- Write FIFO_DEPTH+2 bytes while idle, DIV=3 -> tx_full set after the depth is reached; exactly FIFO_DEPTH+1 bytes transmitted back-to-back with a 2-clk gap; extra bytes dropped.
- Send FIFO_DEPTH+1 bytes with no RX reads -> ovf=1 and irq=1 (irq_en=1); first FIFO_DEPTH bytes are intact; clearing via reg1 bit4 clears ovf.
- MODE=0x23, CTRL=1 -> spi_ss=4'b0100, idle sck=1, cpha=1 sampling verified. dev_num=5 with NUM_SS=4 -> spi_ss=0.
- Read DATA while RX is empty -> cpu_do=0, pointers unchanged. Assert reset mid-SHIFT -> sck=0 and FIFOs empty next clk.
